// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks (divider, adder/subtractor).
// Holds the divider state encoding and the default datapath width.
// Pure declarations; no logic.
package arith_pkg;

    // Default operand width shared with adder_sub users
    localparam int DIV_W = 32;

    // Divider control states; encodings are fixed so other blocks can decode them
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// Trial subtractor for one restoring-division step: rem_shifted - divisor.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the caller in the same cycle.
module div_sub_step
    import arith_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic [N-1:0] rem_shifted,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] w_trial;

    // Extend both operands by one zero bit; the top bit of the result is the borrow
    assign w_trial = {1'b0, rem_shifted} - {1'b0, divisor};
    assign diff    = w_trial[N-1:0];
    assign borrow  = w_trial[N];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: q = a / b, r = a % b, one quotient bit per cycle.
// Latency: N+1 cycles counting the accepting edge (1 cycle for b == 0); done pulses one cycle.
// Backpressure: start is only taken while busy is low; requests during a divide are dropped.
module seq_divider
    import arith_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(N) + 1;

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic [N-1:0]  r_dvd;       // dividend shifting out MSB-first, quotient shifting in at LSB
    logic [N-1:0]  r_rem;       // partial remainder
    logic [N-1:0]  r_div;       // captured divisor
    logic [CW-1:0] r_cnt;       // iterations completed in this divide
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;
    logic          r_div_zero;

    logic [N-1:0]  w_rem_sh;
    logic [N-1:0]  w_diff;
    logic          w_borrow;
    logic [N-1:0]  w_rem_nxt;
    logic [N-1:0]  w_dvd_nxt;
    logic          w_accept;
    logic          w_last;
    logic          w_b_zero;

    // Bring the next dividend bit into the remainder before the trial subtraction
    assign w_rem_sh  = {r_rem[N-2:0], r_dvd[N-1]};

    div_sub_step #(.N(N)) u_step (
        .rem_shifted (w_rem_sh),
        .divisor     (r_div),
        .diff        (w_diff),
        .borrow      (w_borrow)
    );

    // No borrow means the divisor fits: keep the difference and emit a 1 quotient bit
    assign w_rem_nxt = w_borrow ? w_rem_sh : w_diff;
    assign w_dvd_nxt = {r_dvd[N-2:0], ~w_borrow};

    assign w_accept  = start && (r_state != S_RUN);
    assign w_last    = (r_cnt == CW'(N - 1));
    assign w_b_zero  = (b == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus busy/done, which are pure decodes of the current state
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_b_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // A new request in the done cycle chains straight into the next divide
                if (start) begin
                    w_state_nxt = w_b_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, iterate in RUN, publish results on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd      <= '0;
            r_rem      <= '0;
            r_div      <= '0;
            r_cnt      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= a;
            r_div <= b;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_b_zero) begin
                // Divide-by-zero skips the iterations and reports a saturated quotient
                r_q        <= '1;
                r_r        <= a;
                r_div_zero <= 1'b1;
            end else begin
                r_div_zero <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_q <= w_dvd_nxt;
                r_r <= w_rem_nxt;
            end
        end
    end

    assign q        = r_q;
    assign r        = r_r;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider with N = 32.
// Latency is counted in clock edges including the one that accepts start.
// All checks go through check_eq.
module tb_seq_divider;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         div_zero;

    int n_checks;
    int n_fail;

    seq_divider #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for done, sampling 1 time unit after each edge; lat counts edges
    task automatic wait_done(input string tag, inout int lat);
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            check_eq({tag, "_timeout"}, 64'(done), 64'd1);
        end
    endtask

    // Issue one divide and wait for its result
    task automatic run_div(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                           output int lat);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        lat   = 1;
        wait_done(tag, lat);
    endtask

    initial begin
        int lat;
        int rst_done_seen;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [63:0]  recon;

        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst_q",    64'(q),        64'd0);
        check_eq("rst_r",    64'(r),        64'd0);
        check_eq("rst_busy", 64'(busy),     64'd0);
        check_eq("rst_done", 64'(done),     64'd0);
        check_eq("rst_dz",   64'(div_zero), 64'd0);

        // 100 / 7
        run_div("t1", 32'd100, 32'd7, lat);
        check_eq("t1_lat", 64'(lat),      64'd33);
        check_eq("t1_q",   64'(q),        64'd14);
        check_eq("t1_r",   64'(r),        64'd2);
        check_eq("t1_dz",  64'(div_zero), 64'd0);
        check_eq("t1_busy_at_done", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_eq("t1_done_pulse", 64'(done), 64'd0);
        check_eq("t1_q_hold",     64'(q),    64'd14);

        // Extremes
        run_div("t2a", 32'hFFFF_FFFF, 32'd1, lat);
        check_eq("t2a_q", 64'(q), 64'hFFFF_FFFF);
        check_eq("t2a_r", 64'(r), 64'd0);
        run_div("t2b", 32'd3, 32'd10, lat);
        check_eq("t2b_q", 64'(q), 64'd0);
        check_eq("t2b_r", 64'(r), 64'd3);

        // Divide by zero, then a normal divide clears the flag
        run_div("t3a", 32'd5, 32'd0, lat);
        check_eq("t3a_lat", 64'(lat),      64'd1);
        check_eq("t3a_q",   64'(q),        64'hFFFF_FFFF);
        check_eq("t3a_r",   64'(r),        64'd5);
        check_eq("t3a_dz",  64'(div_zero), 64'd1);
        run_div("t3b", 32'd9, 32'd3, lat);
        check_eq("t3b_dz",  64'(div_zero), 64'd0);
        check_eq("t3b_q",   64'(q),        64'd3);
        check_eq("t3b_r",   64'(r),        64'd0);

        // start held high with new operands during RUN, then accepted in the DONE cycle
        @(negedge clk);
        a     = 32'd50;
        b     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        a   = 32'd999;
        b   = 32'd1;
        lat = 1;
        check_eq("t4_busy", 64'(busy), 64'd1);
        wait_done("t4a", lat);
        check_eq("t4a_lat", 64'(lat), 64'd33);
        check_eq("t4a_q",   64'(q),   64'd8);
        check_eq("t4a_r",   64'(r),   64'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        check_eq("t4_rearm_busy", 64'(busy), 64'd1);
        check_eq("t4_rearm_done", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        lat += 5;
        check_eq("t4_q_hold_mid", 64'(q), 64'd8);
        wait_done("t4b", lat);
        check_eq("t4b_lat", 64'(lat), 64'd33);
        check_eq("t4b_q",   64'(q),   64'd999);
        check_eq("t4b_r",   64'(r),   64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        a     = 32'd77;
        b     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("t5_q",    64'(q),        64'd0);
        check_eq("t5_r",    64'(r),        64'd0);
        check_eq("t5_busy", 64'(busy),     64'd0);
        check_eq("t5_done", 64'(done),     64'd0);
        check_eq("t5_dz",   64'(div_zero), 64'd0);
        rst_done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) rst_done_seen = 1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) rst_done_seen = 1;
        end
        check_eq("t5_no_done", 64'(rst_done_seen), 64'd0);
        run_div("t5b", 32'd1000, 32'd10, lat);
        check_eq("t5b_lat", 64'(lat), 64'd33);
        check_eq("t5b_q",   64'(q),   64'd100);
        check_eq("t5b_r",   64'(r),   64'd0);

        // Random operands: q*b + r must rebuild a, and r < b
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'd1;
            run_div("rnd", ra, rb, lat);
            recon = 64'(q) * 64'(rb) + 64'(r);
            check_eq("rnd_recon", recon,       64'(ra));
            check_eq("rnd_rlt_b", 64'(r < rb), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
